// File: rtl/truth_table_scanner.sv
// Truth-table scanner: sweeps a 4-input combinational function through all
// 16 input vectors, captures its output per vector and compares the captured
// table against a golden table latched at start.
module truth_table_scanner #(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] expected,
   input  logic        f_in,
   output logic [3:0]  abcd,
   output logic [15:0] table_out,
   output logic        busy,
   output logic        done,
   output logic        match,
   output logic [4:0]  fail_count,
   output logic [3:0]  first_fail
);

   typedef enum logic [1:0] {StIdle, StApply, StSample, StFinish} state_e;

   // Last value of the settle counter before moving to SAMPLE.
   localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

   state_e      state_q, state_d;
   logic [3:0]  index_q, index_d;
   logic [3:0]  settle_q, settle_d;
   logic [3:0]  abcd_q, abcd_d;
   logic [3:0]  first_fail_q, first_fail_d;
   logic [15:0] exp_q, exp_d;
   logic [15:0] table_q, table_d;
   logic [4:0]  fail_count_q, fail_count_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        match_q, match_d;
   logic        mismatch;

   assign mismatch = (f_in != exp_q[index_q]);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort only matters while a sweep is running.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StApply;
         StApply: begin
            if (abort)                        state_d = StIdle;
            else if (settle_q == SettleLast)  state_d = StSample;
         end
         StSample: begin
            if (abort)                 state_d = StIdle;
            else if (index_q == 4'd15) state_d = StFinish;
            else                       state_d = StApply;
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output/datapath next values; every output is taken from a register.
   always_comb begin
      index_d      = index_q;
      settle_d     = settle_q;
      abcd_d       = abcd_q;
      first_fail_d = first_fail_q;
      exp_d        = exp_q;
      table_d      = table_q;
      fail_count_d = fail_count_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      match_d      = match_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               exp_d        = expected;
               table_d      = '0;
               fail_count_d = '0;
               first_fail_d = '0;
               match_d      = 1'b0;
               index_d      = '0;
               settle_d     = '0;
               abcd_d       = '0;
               busy_d       = 1'b1;
            end
         end
         StApply: begin
            if (abort) begin
               busy_d   = 1'b0;
               abcd_d   = '0;
               settle_d = '0;
            end else if (settle_q == SettleLast) begin
               settle_d = '0;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         StSample: begin
            if (abort) begin
               busy_d = 1'b0;
               abcd_d = '0;
            end else begin
               table_d[index_q] = f_in;
               if (mismatch) begin
                  fail_count_d = fail_count_q + 5'd1;
                  if (fail_count_q == 5'd0) first_fail_d = index_q;
               end
               // abcd is loaded one edge early so it tracks index in APPLY.
               if (index_q == 4'd15) begin
                  abcd_d = '0;
               end else begin
                  index_d = index_q + 4'd1;
                  abcd_d  = index_q + 4'd1;
               end
            end
         end
         StFinish: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            match_d = (fail_count_q == 5'd0);
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_q      <= '0;
         settle_q     <= '0;
         abcd_q       <= '0;
         first_fail_q <= '0;
         exp_q        <= '0;
         table_q      <= '0;
         fail_count_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         match_q      <= 1'b0;
      end else begin
         index_q      <= index_d;
         settle_q     <= settle_d;
         abcd_q       <= abcd_d;
         first_fail_q <= first_fail_d;
         exp_q        <= exp_d;
         table_q      <= table_d;
         fail_count_q <= fail_count_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         match_q      <= match_d;
      end
   end

   assign abcd       = abcd_q;
   assign table_out  = table_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign match      = match_q;
   assign fail_count = fail_count_q;
   assign first_fail = first_fail_q;

endmodule
